// File: rtl/axi_pkg.sv
// Shared AXI encodings, burst control payload, FSM state types and burst legality helpers
// used by axi_slave_mem and axi_burst_addr_gen.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [7:0] len;
    logic [1:0] burst;
  } burst_ctl_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_bad(input logic [7:0] len);
    return !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && wrap_len_bad(len));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Illegal WRAP lengths advance as INCR and raise wrap_bad_c.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE*8-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [SIZE*8-1:0] next_addr_c,
  output logic              wrap_bad_c
);

  localparam int unsigned AW = SIZE * 8;

  logic [AW-1:0] incr_c;
  logic [AW-1:0] mask_c;

  always_comb begin
    incr_c      = addr + AW'(SIZE);
    mask_c      = AW'((32'(len) + 32'd1) * SIZE) - AW'(1);
    wrap_bad_c  = (burst == BURST_WRAP) && wrap_len_bad(len);
    next_addr_c = addr;
    case (burst)
      BURST_INCR: next_addr_c = incr_c;
      BURST_WRAP: next_addr_c = wrap_bad_c ? incr_c : ((addr & ~mask_c) | (incr_c & mask_c));
      default:    next_addr_c = addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI memory slave: independent write and read FSMs over a word array, FIXED/INCR/WRAP bursts.
// Define AXI_SLV_ADDR_CHECK_EN to reject beats at or above DEPTH*SIZE with SLVERR.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned DEPTH = 256
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [SIZE*8-1:0] awadd,
  input  logic [7:0]        awlen,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [SIZE*8-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              aready,
  input  logic [SIZE*8-1:0] aradd,
  input  logic [7:0]        arlen,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [SIZE*8-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast
);

  localparam int unsigned AW    = SIZE * 8;
  localparam int unsigned OFF_W = $clog2(SIZE);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];

  wstate_e       w_state;
  logic [AW-1:0] w_addr;
  burst_ctl_t    w_ctl;
  logic [8:0]    w_cnt;
  logic          w_err;
  logic [AW-1:0] w_next_c;
  logic          w_wrap_bad_c;
  logic          w_oob_c;
  logic          w_fire_c;
  logic          w_in_rng_c;
  logic          w_last_cnt_c;
  logic          w_beat_err_c;
  logic          mem_we_c;
  logic [IDX_W-1:0] w_idx_c;

  rstate_e       r_state;
  logic [AW-1:0] r_addr;
  burst_ctl_t    r_ctl;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_next_c;
  logic          r_wrap_bad_c;
  logic          r_oob_c;
  logic          r_rsv_c;
  logic          r_bad_c;
  logic [IDX_W-1:0] r_idx_c;
  logic [AW-1:0] r_word_c;
  logic [1:0]    r_resp_c;

  axi_burst_addr_gen #(.SIZE(SIZE)) u_wgen (
    .addr        (w_addr),
    .len         (w_ctl.len),
    .burst       (w_ctl.burst),
    .next_addr_c (w_next_c),
    .wrap_bad_c  (w_wrap_bad_c)
  );

  axi_burst_addr_gen #(.SIZE(SIZE)) u_rgen (
    .addr        (r_addr),
    .len         (r_ctl.len),
    .burst       (r_ctl.burst),
    .next_addr_c (r_next_c),
    .wrap_bad_c  (r_wrap_bad_c)
  );

`ifdef AXI_SLV_ADDR_CHECK_EN
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * SIZE);
  assign w_oob_c = (w_addr >= ADDR_LIMIT);
  assign r_oob_c = (r_state == R_IDLE) ? (aradd >= ADDR_LIMIT) : (r_next_c >= ADDR_LIMIT);
`else
  assign w_oob_c = 1'b0;
  assign r_oob_c = 1'b0;
`endif

  // Write beat decode: mismatched wlast and beats past awlen poison the response.
  always_comb begin
    w_idx_c      = w_addr[OFF_W +: IDX_W];
    w_fire_c     = (w_state == W_DATA) && wvalid;
    w_last_cnt_c = (w_cnt == {1'b0, w_ctl.len});
    w_in_rng_c   = (w_cnt <= {1'b0, w_ctl.len});
    w_beat_err_c = (wlast != w_last_cnt_c) || (w_oob_c && w_in_rng_c) ||
                   (w_ctl.burst == BURST_RSVD) || w_wrap_bad_c;
    mem_we_c     = w_fire_c && w_in_rng_c && (w_ctl.burst != BURST_RSVD) && !w_oob_c;
  end

  always_ff @(posedge aclk) begin
    if (mem_we_c) begin
      mem[w_idx_c] <= wdata;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_ctl   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_addr      <= awadd;
            w_ctl.len   <= awlen;
            w_ctl.burst <= awburst;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            awready     <= 1'b0;
            wready      <= 1'b1;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            if (w_in_rng_c) begin
              w_addr <= w_next_c;
              w_cnt  <= w_cnt + 9'd1;
            end
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_err_c) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_err <= w_err || w_beat_err_c;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Source of the next read beat: AR address on accept, generator output while bursting.
  always_comb begin
    if (r_state == R_IDLE) begin
      r_idx_c = aradd[OFF_W +: IDX_W];
      r_rsv_c = (arburst == BURST_RSVD);
      r_bad_c = burst_bad(arburst, arlen);
    end else begin
      r_idx_c = r_next_c[OFF_W +: IDX_W];
      r_rsv_c = (r_ctl.burst == BURST_RSVD);
      r_bad_c = r_rsv_c || r_wrap_bad_c;
    end
    r_word_c = (r_rsv_c || r_oob_c) ? '0 : mem[r_idx_c];
    r_resp_c = (r_bad_c || r_oob_c) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_ctl   <= '0;
      r_cnt   <= '0;
      aready  <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_addr      <= aradd;
            r_ctl.len   <= arlen;
            r_ctl.burst <= arburst;
            r_cnt       <= '0;
            aready      <= 1'b0;
            rvalid      <= 1'b1;
            rdata       <= r_word_c;
            rresp       <= r_resp_c;
            rlast       <= (arlen == 8'd0);
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= RESP_OKAY;
              aready  <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next_c;
              r_cnt  <= r_cnt + 8'd1;
              rdata  <= r_word_c;
              rresp  <= r_resp_c;
              rlast  <= ((r_cnt + 8'd1) == r_ctl.len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized scoreboard bench for axi_slave_mem against an arithmetic burst/memory model.
// Honours AXI_SLV_ADDR_CHECK_EN in the model when the macro is defined.
module tb_axi_slave_mem;

  logic        aclk;
  logic        resetn;
  logic        awvalid;
  logic        awready;
  logic [31:0] awadd;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        aready;
  logic [31:0] aradd;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  axi_slave_mem #(.SIZE(4), .DEPTH(256)) dut (
    .aclk(aclk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awadd(awadd), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .aready(aready), .aradd(aradd), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  int          tests = 0;
  int          fails = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [31:0] mem_m [256];
  bit          bp_rand;
  bit          man_rready;
  bit          man_bready;
  bit          stall_valid;
  logic [31:0] hold_data;
  logic [1:0]  hold_resp;
  logic        hold_last;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-address rules in plain arithmetic.
  function automatic bit m_wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input int len, input int bu);
    longint unsigned bound;
    longint unsigned base;
    if (bu == 1 || (bu == 2 && !m_wrap_ok(len))) return a + 32'd4;
    if (bu == 2) begin
      bound = longint'(len + 1) * 4;
      base  = longint'(a) - (longint'(a) % bound);
      return 32'(base + ((longint'(a) - base + 4) % bound));
    end
    return a;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  function automatic bit m_oob(input logic [31:0] a);
`ifdef AXI_SLV_ADDR_CHECK_EN
    return a >= 32'd1024;
`else
    return a > 32'hFFFF_FFFF;
`endif
  endfunction

  // Ready generator: random backpressure or manual values.
  always @(posedge aclk) begin
    #2;
    rready = bp_rand ? (($urandom % 4) != 0) : man_rready;
    bready = bp_rand ? (($urandom % 3) != 0) : man_bready;
  end

  // Monitor: pops the scoreboard on every B/R handshake, checks stability during R stalls.
  always @(negedge aclk) begin
    if (!resetn) begin
      stall_valid = 1'b0;
    end else begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'(bq.size()), 1);
        else check("bresp", 32'(bresp), 32'(bq.pop_front()));
      end
      if (rvalid) begin
        if (stall_valid) begin
          check("r_hold_data", rdata, hold_data);
          check("r_hold_ctl", {29'd0, rresp, rlast}, {29'd0, hold_resp, hold_last});
        end
        if (rready) begin
          stall_valid = 1'b0;
          if (rq.size() == 0) begin
            check("r_unexpected", 32'(rq.size()), 1);
          end else begin
            rexp_t e;
            e = rq.pop_front();
            check("rdata", rdata, e.data);
            check("rresp_rlast", {29'd0, rresp, rlast}, {29'd0, e.resp, e.last});
          end
        end else begin
          stall_valid = 1'b1;
          hold_data   = rdata;
          hold_resp   = rresp;
          hold_last   = rlast;
        end
      end else begin
        stall_valid = 1'b0;
      end
    end
  end

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    bit ok;
    awadd = a; awlen = len; awburst = bu; awvalid = 1'b1;
    do begin @(negedge aclk); ok = awready; @(posedge aclk); #1; n++; end while (!ok && n < 100);
    awvalid = 1'b0;
    check("aw_handshake", 32'(ok), 1);
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    bit ok;
    aradd = a; arlen = len; arburst = bu; arvalid = 1'b1;
    do begin @(negedge aclk); ok = aready; @(posedge aclk); #1; n++; end while (!ok && n < 100);
    arvalid = 1'b0;
    check("ar_handshake", 32'(ok), 1);
  endtask

  task automatic do_wbeat(input logic [31:0] d, input logic last, input bit gaps);
    int n = 0;
    bit ok;
    if (gaps && ($urandom % 4) == 0) begin wvalid = 1'b0; @(posedge aclk); #1; end
    wvalid = 1'b1; wdata = d; wlast = last;
    do begin @(negedge aclk); ok = wready; @(posedge aclk); #1; n++; end while (!ok && n < 100);
    wvalid = 1'b0; wlast = 1'b0;
    check("w_handshake", 32'(ok), 1);
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input int bu, input int nb,
                          input bit fixed, input logic [31:0] seed, input bit gaps);
    logic [31:0] ad;
    logic [31:0] dq[$];
    logic [31:0] d;
    bit err;
    ad  = a;
    err = (nb != len + 1) || (bu == 3) || (bu == 2 && !m_wrap_ok(len));
    for (int k = 0; k < nb; k++) begin
      d = fixed ? seed + 32'(k) : $urandom;
      dq.push_back(d);
      if (k <= len) begin
        if (m_oob(ad)) err = 1'b1;
        else if (bu != 3) mem_m[m_idx(ad)] = d;
        ad = m_next(ad, len, bu);
      end
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    do_aw(a, 8'(len), 2'(bu));
    for (int k = 0; k < nb; k++) do_wbeat(dq[k], k == nb - 1, gaps);
    check("b_after_wlast", 32'(bvalid), 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input int bu);
    logic [31:0] ad;
    rexp_t e;
    bit bad;
    ad = a;
    for (int k = 0; k <= len; k++) begin
      bad    = m_oob(ad) || bu == 3;
      e.data = bad ? 32'd0 : mem_m[m_idx(ad)];
      e.resp = (bad || (bu == 2 && !m_wrap_ok(len))) ? 2'b10 : 2'b00;
      e.last = (k == len);
      rq.push_back(e);
      ad = m_next(ad, len, bu);
    end
    do_ar(a, 8'(len), 2'(bu));
    check("r_after_ar", 32'(rvalid), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 4000) begin @(posedge aclk); n++; end
    check("drain", 32'(bq.size() + rq.size()), 0);
    bq.delete();
    rq.delete();
    @(posedge aclk); #1;
  endtask

  initial begin
    int len, bu, nb, sel;
    logic [31:0] a;
    resetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0;
    awadd = '0; awlen = '0; awburst = '0; wdata = '0; aradd = '0; arlen = '0; arburst = '0;
    bp_rand = 1'b1; man_rready = 1'b1; man_bready = 1'b1; stall_valid = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 32'(awready), 1);
    check("rst_aready", 32'(aready), 1);
    check("rst_valids", {28'd0, wready, bvalid, rvalid, rlast}, 0);
    check("rst_resps", {28'd0, bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    @(posedge aclk); #1;
    resetn = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 16; i++) begin
      do_write(32'(i * 64), 15, 1, 16, 1'b0, '0, 1'b0);
      wait_drain();
    end

    do_write(32'h10, 3, 1, 4, 1'b1, 32'hA0, 1'b0);
    wait_drain();
    do_read(32'h08, 3, 2);
    wait_drain();

    // Backpressure on the third beat of an INCR read.
    bp_rand = 1'b0; man_rready = 1'b0;
    @(posedge aclk); #1;
    do_read(32'h10, 3, 1);
    man_rready = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    man_rready = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    man_rready = 1'b1;
    wait_drain();

    // Early wlast with the response held off.
    man_bready = 1'b0;
    do_write(32'h40, 3, 1, 3, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin @(negedge aclk); check("bvalid_hold", 32'(bvalid), 1); end
    man_bready = 1'b1;
    wait_drain();
    bp_rand = 1'b1;

    do_write(32'd1024, 0, 1, 1, 1'b0, '0, 1'b0);
    wait_drain();
    do_read(32'd1024, 0, 1);
    wait_drain();
    do_write(32'hFFFF_FFF8, 3, 1, 4, 1'b0, '0, 1'b0);
    wait_drain();
    do_read(32'hFFFF_FFF8, 3, 1);
    wait_drain();

    fork
      do_write(32'h320, 3, 1, 4, 1'b0, '0, 1'b0);
      do_read(32'h0, 1, 1);
    join
    wait_drain();

    // Reset in the middle of a write and a stalled read.
    bp_rand = 1'b0; man_rready = 1'b0; man_bready = 1'b1;
    @(posedge aclk); #1;
    do_ar(32'h200, 3, 1);
    do_aw(32'h100, 3, 1);
    for (int k = 0; k < 2; k++) begin
      a = $urandom;
      mem_m[m_idx(32'h100 + 32'(4 * k))] = a;
      do_wbeat(a, 1'b0, 1'b0);
    end
    resetn = 1'b0;
    #1;
    check("mid_rst_awready", 32'(awready), 1);
    check("mid_rst_aready", 32'(aready), 1);
    check("mid_rst_valids", {29'd0, wready, bvalid, rvalid}, 0);
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;
    bp_rand = 1'b1; man_rready = 1'b1;
    @(posedge aclk); #1;
    do_read(32'h100, 3, 1);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom % 8);
      if (sel == 0) a = 32'hFFFF_FFF0 + 32'(4 * ($urandom % 4));
      else if (sel == 1) a = 32'd1024 + 32'(4 * ($urandom % 16));
      else a = 32'(4 * ($urandom % 256));
      sel = int'($urandom % 8);
      bu = (sel == 0) ? 0 : (sel < 4) ? 1 : (sel < 7) ? 2 : 3;
      if (bu == 2) begin
        sel = int'($urandom % 5);
        len = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 7 : (sel == 3) ? 15 : 2;
      end else begin
        len = int'($urandom % 8);
      end
      if (($urandom % 2) == 0) begin
        sel = int'($urandom % 8);
        nb  = (sel == 0) ? len + 2 : (sel == 1 && len > 0) ? len : len + 1;
        do_write(a, len, bu, nb, 1'b0, '0, 1'b1);
      end else begin
        do_read(a, len, bu);
      end
      wait_drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
